// File: rtl/frogger_pkg.sv
// Shared constants for the Frogger traffic block: playfield width, lane rows,
// per-car base periods and start columns, and the traffic state encoding.
package frogger_pkg;

    localparam int c_GAME_WIDTH   = 14;
    localparam int c_LANE_Y_BASE  = 2;
    localparam int c_FREEZE_TICKS = 8;

    localparam int c_NUM_CARS  = 6;
    localparam int c_X_W       = 6;
    localparam int c_LEVEL_W   = 3;
    localparam int c_LEVEL_MAX = 7;

    // Index 0 is car 1
    localparam int c_BASE_PERIOD [c_NUM_CARS] = '{4, 3, 5, 2, 6, 3};
    localparam int c_INIT_X      [c_NUM_CARS] = '{0, 3, 6, 9, 12, 2};

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StFreeze = 1'b1
    } traffic_state_e;

endpackage

// File: rtl/frogger_lane_mover.sv
// One car: a tick counter that divides game ticks by the level-adjusted
// period, and an X register that wraps across the playfield.
module frogger_lane_mover
    import frogger_pkg::*;
#(
    parameter int c_GAME_WIDTH  = frogger_pkg::c_GAME_WIDTH,
    parameter bit p_DIR_UP      = 1'b1,
    parameter int p_BASE_PERIOD = 4,
    parameter int p_INIT_X      = 0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Restart,
    input  logic                 i_Step_En,
    input  logic [c_LEVEL_W-1:0] i_Level,
    output logic [c_X_W-1:0]     o_X
);

    localparam int c_CNT_W = 4;

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [c_X_W-1:0]   x_q, x_d;
    logic [c_X_W-1:0]   x_next;
    int                 eff_period;

    // Effective period shrinks with level but never below one tick
    always_comb begin
        eff_period = p_BASE_PERIOD - int'(i_Level);
        if (eff_period < 1) begin
            eff_period = 1;
        end
    end

    // Wrapping one-column move in this car's direction
    always_comb begin
        x_next = x_q;
        if (p_DIR_UP) begin
            x_next = (x_q == c_X_W'(c_GAME_WIDTH - 1)) ? '0 : x_q + c_X_W'(1);
        end else begin
            x_next = (x_q == '0) ? c_X_W'(c_GAME_WIDTH - 1) : x_q - c_X_W'(1);
        end
    end

    // Restart beats stepping; a step happens on the tick that completes a period
    always_comb begin
        cnt_d = cnt_q;
        x_d   = x_q;
        if (i_Restart) begin
            cnt_d = '0;
            x_d   = c_X_W'(p_INIT_X);
        end else if (i_Step_En) begin
            if (cnt_q == c_CNT_W'(eff_period - 1)) begin
                cnt_d = '0;
                x_d   = x_next;
            end else begin
                cnt_d = cnt_q + c_CNT_W'(1);
            end
        end
    end

    // Counter and position registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
            x_q   <= c_X_W'(p_INIT_X);
        end else begin
            cnt_q <= cnt_d;
            x_q   <= x_d;
        end
    end

    assign o_X = x_q;

endmodule

// File: rtl/frogger_traffic.sv
// Frogger traffic: six wrapping cars, difficulty level, and an optional
// post-collision freeze enabled by defining FROGGER_TRAFFIC_FREEZE_EN.
module frogger_traffic
    import frogger_pkg::*;
#(
    parameter int c_GAME_WIDTH   = frogger_pkg::c_GAME_WIDTH,
    parameter int c_LANE_Y_BASE  = frogger_pkg::c_LANE_Y_BASE,
    parameter int c_FREEZE_TICKS = frogger_pkg::c_FREEZE_TICKS
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Game_Tick,
    input  logic                 i_Level_Up,
    input  logic                 i_Collided,
    output logic [c_X_W-1:0]     o_Car_X_1,
    output logic [c_X_W-1:0]     o_Car_X_2,
    output logic [c_X_W-1:0]     o_Car_X_3,
    output logic [c_X_W-1:0]     o_Car_X_4,
    output logic [c_X_W-1:0]     o_Car_X_5,
    output logic [c_X_W-1:0]     o_Car_X_6,
    output logic [c_X_W-1:0]     o_Car_Y_1,
    output logic [c_X_W-1:0]     o_Car_Y_2,
    output logic [c_X_W-1:0]     o_Car_Y_3,
    output logic [c_X_W-1:0]     o_Car_Y_4,
    output logic [c_X_W-1:0]     o_Car_Y_5,
    output logic [c_X_W-1:0]     o_Car_Y_6,
    output logic [c_LEVEL_W-1:0] o_Level,
    output logic                 o_Frozen
);

    logic [c_LEVEL_W-1:0] level_q, level_d;
    logic                 run;
    logic                 step_en;
    logic [c_X_W-1:0]     car_x [c_NUM_CARS];

    // Saturating difficulty level
    always_comb begin
        level_d = level_q;
        if (i_Level_Up && (level_q != c_LEVEL_W'(c_LEVEL_MAX))) begin
            level_d = level_q + c_LEVEL_W'(1);
        end
    end

    // Level register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

`ifdef FROGGER_TRAFFIC_FREEZE_EN
    localparam int c_FRZ_W = (c_FREEZE_TICKS > 1) ? $clog2(c_FREEZE_TICKS) : 1;

    traffic_state_e     state_q, state_d;
    logic               rearm_q, rearm_d;
    logic               frozen_q, frozen_d;
    logic [c_FRZ_W-1:0] freeze_cnt_q, freeze_cnt_d;

    // RUN/FREEZE next state; a level-up always restarts traffic in RUN.
    // rearm stops a collision flag that stays high from re-freezing.
    always_comb begin
        state_d      = state_q;
        rearm_d      = rearm_q;
        freeze_cnt_d = freeze_cnt_q;
        if (i_Level_Up) begin
            state_d      = StRun;
            freeze_cnt_d = '0;
            if (!i_Collided) begin
                rearm_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (i_Collided) begin
                        if (rearm_q) begin
                            state_d      = StFreeze;
                            rearm_d      = 1'b0;
                            freeze_cnt_d = '0;
                        end
                    end else begin
                        rearm_d = 1'b1;
                    end
                end
                StFreeze: begin
                    if (i_Game_Tick) begin
                        if (freeze_cnt_q == c_FRZ_W'(c_FREEZE_TICKS - 1)) begin
                            state_d      = StRun;
                            freeze_cnt_d = '0;
                        end else begin
                            freeze_cnt_d = freeze_cnt_q + c_FRZ_W'(1);
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
        frozen_d = (state_d == StFreeze);
    end

    // FSM state with registered frozen flag
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= StRun;
            rearm_q      <= 1'b1;
            frozen_q     <= 1'b0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rearm_q      <= rearm_d;
            frozen_q     <= frozen_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign run      = (state_q == StRun);
    assign o_Frozen = frozen_q;
`else
    localparam int unused_freeze_ticks = c_FREEZE_TICKS;
    logic unused_collided;

    assign unused_collided = i_Collided;
    assign run             = 1'b1;
    assign o_Frozen        = 1'b0;
`endif

    // A level-up discards a coincident tick
    assign step_en = i_Game_Tick && run && !i_Level_Up;

    for (genvar i = 0; i < c_NUM_CARS; i++) begin : g_car
        frogger_lane_mover #(
            .c_GAME_WIDTH (c_GAME_WIDTH),
            .p_DIR_UP     ((i % 2) == 0),
            .p_BASE_PERIOD(c_BASE_PERIOD[i]),
            .p_INIT_X     (c_INIT_X[i])
        ) u_lane (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Restart(i_Level_Up),
            .i_Step_En(step_en),
            .i_Level  (level_q),
            .o_X      (car_x[i])
        );
    end

    assign o_Car_X_1 = car_x[0];
    assign o_Car_X_2 = car_x[1];
    assign o_Car_X_3 = car_x[2];
    assign o_Car_X_4 = car_x[3];
    assign o_Car_X_5 = car_x[4];
    assign o_Car_X_6 = car_x[5];

    // Each car keeps its lane row forever
    assign o_Car_Y_1 = c_X_W'(c_LANE_Y_BASE + 0);
    assign o_Car_Y_2 = c_X_W'(c_LANE_Y_BASE + 1);
    assign o_Car_Y_3 = c_X_W'(c_LANE_Y_BASE + 2);
    assign o_Car_Y_4 = c_X_W'(c_LANE_Y_BASE + 3);
    assign o_Car_Y_5 = c_X_W'(c_LANE_Y_BASE + 4);
    assign o_Car_Y_6 = c_X_W'(c_LANE_Y_BASE + 5);

    assign o_Level = level_q;

endmodule

// File: tb/tb_frogger_traffic.sv
// Directed bench for frogger_traffic; freeze checks follow
// FROGGER_TRAFFIC_FREEZE_EN.
module tb_frogger_traffic;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       tick;
    logic       lvl_up;
    logic       collided;
    logic [5:0] cx [1:6];
    logic [5:0] cy [1:6];
    logic [2:0] level;
    logic       frozen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frogger_traffic dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_Game_Tick(tick),
        .i_Level_Up (lvl_up),
        .i_Collided (collided),
        .o_Car_X_1  (cx[1]),
        .o_Car_X_2  (cx[2]),
        .o_Car_X_3  (cx[3]),
        .o_Car_X_4  (cx[4]),
        .o_Car_X_5  (cx[5]),
        .o_Car_X_6  (cx[6]),
        .o_Car_Y_1  (cy[1]),
        .o_Car_Y_2  (cy[2]),
        .o_Car_Y_3  (cy[3]),
        .o_Car_Y_4  (cy[4]),
        .o_Car_Y_5  (cy[5]),
        .o_Car_Y_6  (cy[6]),
        .o_Level    (level),
        .o_Frozen   (frozen)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle tick pulse followed by one idle cycle
    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_init(input string tag);
        check({tag, "_x1"}, 32'(cx[1]), 0);
        check({tag, "_x2"}, 32'(cx[2]), 3);
        check({tag, "_x3"}, 32'(cx[3]), 6);
        check({tag, "_x4"}, 32'(cx[4]), 9);
        check({tag, "_x5"}, 32'(cx[5]), 12);
        check({tag, "_x6"}, 32'(cx[6]), 2);
    endtask

    task automatic pulse_level_up();
        lvl_up = 1'b1;
        @(negedge clk);
        lvl_up = 1'b0;
    endtask

    initial begin
        int e2 [4];
        e2 = '{2, 1, 0, 13};
        rst_l    = 1'b0;
        tick     = 1'b0;
        lvl_up   = 1'b0;
        collided = 1'b0;
        cyc(2);

        // Reset state
        check_init("reset");
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("reset_y%0d", k), 32'(cy[k]), 32'(k + 1));
        end
        check("reset_level", 32'(level), 0);
        check("reset_frozen", 32'(frozen), 0);

        // Four ticks at level 0
        rst_l = 1'b1;
        cyc(1);
        tick_n(4);
        check("t4_x1", 32'(cx[1]), 1);
        check("t4_x2", 32'(cx[2]), 2);
        check("t4_x3", 32'(cx[3]), 6);
        check("t4_x4", 32'(cx[4]), 7);
        check("t4_x5", 32'(cx[5]), 12);
        check("t4_x6", 32'(cx[6]), 1);

        // Wrap in both directions
        rst_l = 1'b0;
        cyc(1);
        rst_l = 1'b1;
        cyc(1);
        for (int s = 0; s < 4; s++) begin
            tick_n(3);
            check($sformatf("wrap_x2_step%0d", s), 32'(cx[2]), 32'(e2[s]));
            if (s == 1) check("wrap_x5_a", 32'(cx[5]), 13);
            if (s == 3) check("wrap_x5_b", 32'(cx[5]), 0);
        end

        // Level-up coinciding with a tick: restart wins, counters clear
        tick_n(1);
        check("pre_lvl_x4", 32'(cx[4]), 3);
        tick   = 1'b1;
        lvl_up = 1'b1;
        @(negedge clk);
        tick   = 1'b0;
        lvl_up = 1'b0;
        check_init("lvl_tick");
        check("lvl_tick_level", 32'(level), 1);
        tick_n(1);
        check("lvl1_t1_x1", 32'(cx[1]), 0);
        check("lvl1_t1_x4", 32'(cx[4]), 8);
        tick_n(2);
        check("lvl1_t3_x1", 32'(cx[1]), 1);
        check("lvl1_t3_x4", 32'(cx[4]), 6);
        check("lvl1_t3_x6", 32'(cx[6]), 1);

        // Level climbs to 7 and saturates; positions restart each time
        for (int lv = 2; lv <= 7; lv++) begin
            pulse_level_up();
            check($sformatf("level_%0d", lv), 32'(level), 32'(lv));
            check_init($sformatf("lvl%0d", lv));
        end
        pulse_level_up();
        check("level_sat", 32'(level), 7);
        tick_n(1);
        check("lvl7_x4", 32'(cx[4]), 8);
        check("lvl7_x1", 32'(cx[1]), 1);
        check("lvl7_x5", 32'(cx[5]), 13);

        // Collision held high for 20 cycles
        rst_l = 1'b0;
        cyc(1);
        rst_l = 1'b1;
        cyc(1);
        collided = 1'b1;
        cyc(1);
`ifdef FROGGER_TRAFFIC_FREEZE_EN
        check("col_frozen", 32'(frozen), 1);
        tick_n(7);
        check("frz7_frozen", 32'(frozen), 1);
        check("frz7_x1", 32'(cx[1]), 0);
        check("frz7_x4", 32'(cx[4]), 9);
        tick_n(1);
        check("frz8_frozen", 32'(frozen), 0);
        check("frz8_x1", 32'(cx[1]), 0);
        cyc(3);
        check("no_retrigger", 32'(frozen), 0);
        tick_n(4);
        check("post_x1", 32'(cx[1]), 1);
        check("post_x4", 32'(cx[4]), 7);
        check("post_frozen", 32'(frozen), 0);
        collided = 1'b0;
        cyc(1);
        collided = 1'b1;
        cyc(1);
        check("rearm_frozen", 32'(frozen), 1);
`else
        check("col_frozen", 32'(frozen), 0);
        tick_n(7);
        check("nf7_frozen", 32'(frozen), 0);
        check("nf7_x1", 32'(cx[1]), 1);
        check("nf7_x4", 32'(cx[4]), 6);
        tick_n(1);
        check("nf8_x1", 32'(cx[1]), 2);
        cyc(3);
        check("nf_frozen", 32'(frozen), 0);
        tick_n(4);
        check("nf12_x1", 32'(cx[1]), 3);
        check("nf12_x4", 32'(cx[4]), 3);
        collided = 1'b0;
        cyc(1);
        collided = 1'b1;
        cyc(1);
        check("nf_rearm_frozen", 32'(frozen), 0);
`endif

        // Asynchronous reset during freeze clears it immediately
        rst_l = 1'b0;
        #1;
        check("rst_frozen", 32'(frozen), 0);
        check("rst_x1", 32'(cx[1]), 0);
        collided = 1'b0;
        cyc(1);
        rst_l = 1'b1;
        cyc(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
